// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK, CS_n and MOSI in the i_Clk domain and shifts bytes MSB first.
// Optional: define SPI_SLAVE_UNDERRUN_EN to add the o_TX_Underrun pulse output.
module spi_slave #(
  parameter int         SPI_MODE     = 0,
  parameter logic [7:0] DEFAULT_BYTE = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Busy,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
`ifdef SPI_SLAVE_UNDERRUN_EN
  output logic       o_SPI_MISO_En,
  output logic       o_TX_Underrun
`else
  output logic       o_SPI_MISO_En
`endif
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  state_t     next_state;

  logic       sck_meta, sck_sync, sck_prev;
  logic       cs_meta, cs_sync, cs_prev;
  logic       mosi_meta, mosi_sync;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       miso_bit;
  logic [7:0] hold_byte;
  logic       hold_valid;

  logic       lead_edge, trail_edge;
  logic       cs_fall, cs_rise;
  logic       in_frame, sample_now, shift_now;
  logic       byte_done, reload;

  // The *_prev stages form the edge detector, giving a fixed 3-cycle pin-to-action latency.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_meta  <= CPOL;
      sck_sync  <= CPOL;
      sck_prev  <= CPOL;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sck_meta  <= i_SPI_Clk;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= i_SPI_CS_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= i_SPI_MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  assign lead_edge  = (sck_sync != CPOL) && (sck_prev == CPOL);
  assign trail_edge = (sck_sync == CPOL) && (sck_prev != CPOL);
  assign cs_fall    = cs_prev && !cs_sync;
  assign cs_rise    = !cs_prev && cs_sync;

  // A CS release on the same cycle as an SCK edge wins: the edge is dropped.
  assign in_frame   = (state == ACTIVE) && !cs_rise;
  assign sample_now = in_frame && (CPHA ? trail_edge : lead_edge);
  assign shift_now  = in_frame && (CPHA ? lead_edge : trail_edge);
  assign byte_done  = sample_now && (bit_cnt == 3'd0);
  assign reload     = ((state == IDLE) && cs_fall) || byte_done;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = ACTIVE;
      ACTIVE:  if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_Busy        = 1'b0;
    o_SPI_MISO_En = 1'b0;
    o_SPI_MISO    = 1'b0;
    if (state == ACTIVE) begin
      o_Busy        = 1'b1;
      o_SPI_MISO_En = 1'b1;
      o_SPI_MISO    = CPHA ? miso_bit : tx_shift[7];
    end
  end

  // A write coinciding with a reload is queued; the reload still sees the old content.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_byte  <= 8'h00;
      hold_valid <= 1'b0;
    end else if (i_TX_DV) begin
      hold_byte  <= i_TX_Byte;
      hold_valid <= 1'b1;
    end else if (reload) begin
      hold_valid <= 1'b0;
    end
  end

  assign o_TX_Ready = !hold_valid;

  // In CPHA=0 the trailing edge right after a byte's last sample must not disturb the fresh bit 7.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_shift <= 8'h00;
      miso_bit <= 1'b0;
    end else if (reload) begin
      tx_shift <= hold_valid ? hold_byte : DEFAULT_BYTE;
    end else if (shift_now && (CPHA || (bit_cnt != 3'd7))) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
      miso_bit <= tx_shift[7];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt   <= 3'd7;
      rx_shift  <= 7'h00;
      o_RX_Byte <= 8'h00;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (!in_frame) begin
        bit_cnt <= 3'd7;
      end else if (sample_now) begin
        bit_cnt  <= bit_cnt - 3'd1;
        rx_shift <= {rx_shift[5:0], mosi_sync};
        if (bit_cnt == 3'd0) begin
          o_RX_Byte <= {rx_shift, mosi_sync};
          o_RX_DV   <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_TX_Underrun <= 1'b0;
    end else begin
      o_TX_Underrun <= reload && !hold_valid;
    end
  end
`endif

endmodule
